// File: rtl/spi_seq_pkg.sv
// Shared constants for the SPI command sequencer: opcodes, header field
// positions, error bit indices and the sequencer state encoding.
package spi_seq_pkg;

    localparam logic [7:0] OP_INCR  = 8'hA5;
    localparam logic [7:0] OP_FIXED = 8'h5A;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 24;
    localparam int ADDR_MSB = 23;
    localparam int ADDR_LSB = 16;
    localparam int CNT_MSB  = 15;
    localparam int CNT_LSB  = 8;

    localparam int ERR_HDR   = 0;
    localparam int ERR_OVF   = 1;
    localparam int ERR_ABORT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

endpackage

// File: rtl/spi_seq_fifo.sv
// Write-buffer FIFO for the sequencer. Push into a full FIFO is accepted only
// when a pop happens in the same cycle; flush wins over push and pop.
module spi_seq_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             SCLK,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign head  = mem_q[rd_ptr_q];

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty && !flush;
        do_push  = push && (!full || do_pop) && !flush;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_d = count_q + (PW+1)'(1);
            else if (do_pop && !do_push) count_d = count_q - (PW+1)'(1);
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define validity.
    always_ff @(posedge SCLK) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Turns an SPI word stream (header + N data words) into buffered register writes.
// Optional header parity check is enabled by defining SPI_SEQ_PARITY_EN.
module spi_cmd_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  SCLK,
    input  logic                  reset,
    input  logic                  ss_n,
    input  logic                  word_valid,
    input  logic [DATA_WIDTH-1:0] word_data,
    output logic                  wr_req,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_gnt,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            err
);

    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            remaining_q, remaining_d;
    logic                  incr_q, incr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [2:0]            err_q, err_d;

    logic          word_in, hdr_ok, parity_ok, pop_eff;
    logic          fifo_push, fifo_flush, fifo_full, fifo_empty;
    logic [EW-1:0] fifo_head;
    logic [7:0]    opcode, count;

    assign word_in = word_valid && !ss_n;
    assign opcode  = word_data[OPC_MSB:OPC_LSB];
    assign count   = word_data[CNT_MSB:CNT_LSB];
    assign pop_eff = wr_gnt && !fifo_empty;

`ifdef SPI_SEQ_PARITY_EN
    // Bit 0 carries even parity over [31:1], so the whole word XORs to zero.
    assign parity_ok = ~^word_data[OPC_MSB:0];
`else
    assign parity_ok = 1'b1;
`endif

    assign hdr_ok = ((opcode == OP_INCR) || (opcode == OP_FIXED)) && (count != 8'd0) && parity_ok;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        incr_d      = incr_q;
        err_d       = err_q;
        done_d      = 1'b0;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (word_in) begin
                    if (hdr_ok) begin
                        err_d       = '0;
                        addr_d      = ADDR_WIDTH'(word_data[ADDR_MSB:ADDR_LSB]);
                        remaining_d = count;
                        incr_d      = (opcode == OP_INCR);
                        state_d     = ST_DATA;
                    end else begin
                        err_d[ERR_HDR] = 1'b1;
                        state_d        = ST_ERR;
                    end
                end
            end
            ST_DATA: begin
                if (ss_n) begin
                    fifo_flush       = 1'b1;
                    err_d[ERR_ABORT] = 1'b1;
                    state_d          = ST_IDLE;
                end else if (word_valid) begin
                    // A dropped word still consumes its slot in the burst.
                    fifo_push   = 1'b1;
                    if (fifo_full && !pop_eff) err_d[ERR_OVF] = 1'b1;
                    remaining_d = remaining_q - 8'd1;
                    if (incr_q) addr_d = addr_q + ADDR_WIDTH'(1);
                    if (remaining_q == 8'd1) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_ERR: begin
                if (ss_n) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            incr_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            incr_q      <= incr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    spi_seq_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .SCLK      (SCLK),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({addr_q, word_data}),
        .pop       (wr_gnt),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Head storage is unreset, so the write port reads as zero whenever nothing is queued.
    assign wr_req  = !fifo_empty;
    assign wr_addr = fifo_empty ? '0 : fifo_head[EW-1:DATA_WIDTH];
    assign wr_data = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: expected writes are queued as words
// are driven and checked by a write-port monitor on the falling clock edge.
module tb_spi_cmd_sequencer;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          SCLK = 1'b0;
    logic          reset = 1'b0;
    logic          ss_n = 1'b1;
    logic          word_valid = 1'b0;
    logic [DW-1:0] word_data = '0;
    logic          wr_gnt = 1'b0;
    logic          wr_req, busy, done;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [2:0]    err;

    int tests_run = 0;
    int tests_failed = 0;
    int wr_count = 0;
    int done_count = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_exp;

    always #5 SCLK = ~SCLK;

    spi_cmd_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
        .SCLK       (SCLK),
        .reset      (reset),
        .ss_n       (ss_n),
        .word_valid (word_valid),
        .word_data  (word_data),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_gnt     (wr_gnt),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // A transfer happens on the next rising edge whenever wr_req and wr_gnt are both high here.
    always @(negedge SCLK) begin
        if (reset && done) done_count++;
        if (reset && wr_req && wr_gnt) begin
            wr_count++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL write_unexpected: got addr=%h data=%h, required no write", wr_addr, wr_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({wr_addr, wr_data} !== mon_exp) begin
                    tests_failed++;
                    $display("FAIL write_content: got addr=%h data=%h, required addr=%h data=%h",
                             wr_addr, wr_data, mon_exp[AW+DW-1:DW], mon_exp[DW-1:0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge SCLK);
        #1;
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        word_valid = 1'b1;
        word_data  = w;
        tick(1);
        word_valid = 1'b0;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || wr_req) && n < 100) begin
            tick(1);
            n++;
        end
        tests_run++;
        if (busy || wr_req) begin
            tests_failed++;
            $display("FAIL %s_timeout: busy=%b wr_req=%b after %0d cycles, required idle", name, busy, wr_req, n);
        end
        tick(1);
    endtask

    task automatic test_reset();
        tick(2);
        tests_run++;
        if ({wr_req, wr_addr, wr_data, busy, done, err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got wr_req=%b addr=%h data=%h busy=%b done=%b err=%b, required all zero",
                     wr_req, wr_addr, wr_data, busy, done, err);
        end
        reset = 1'b1;
        tick(2);
    endtask

    task automatic test_incr();
        int d0, w0;
        d0 = done_count;
        w0 = wr_count;
        wr_gnt = 1'b1;
        ss_n   = 1'b0;
        send_word(32'hA5_10_03_00);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL incr_busy: got %b, required 1", busy);
        end
        expect_wr(8'h10, 32'h11); send_word(32'h11);
        expect_wr(8'h11, 32'h22); send_word(32'h22);
        expect_wr(8'h12, 32'h33); send_word(32'h33);
        wait_idle("incr");
        ss_n = 1'b1;
        tests_run++;
        if (done_count - d0 != 1 || wr_count - w0 != 3) begin
            tests_failed++;
            $display("FAIL incr_counts: got done=%0d writes=%0d, required done=1 writes=3", done_count - d0, wr_count - w0);
        end
        tests_run++;
        if (err !== 3'b000) begin
            tests_failed++;
            $display("FAIL incr_err: got %b, required 000", err);
        end
    endtask

    task automatic test_fixed_wrap();
        wr_gnt = 1'b1;
        ss_n   = 1'b0;
        send_word(32'h5A_FF_02_00);
        expect_wr(8'hFF, 32'h0A); send_word(32'h0A);
        expect_wr(8'hFF, 32'h0B); send_word(32'h0B);
        wait_idle("fixed");
        send_word(32'hA5_FF_02_00);
        expect_wr(8'hFF, 32'h0C); send_word(32'h0C);
        expect_wr(8'h00, 32'h0D); send_word(32'h0D);
        wait_idle("wrap");
        ss_n = 1'b1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL wrap_pending: got %0d writes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_bad_header();
        int w0;
        w0 = wr_count;
        wr_gnt = 1'b1;
        ss_n   = 1'b0;
        send_word(32'h33_00_01_00);
        send_word(32'h99);
        tests_run++;
        if (err !== 3'b001 || busy !== 1'b1 || wr_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL bad_opcode: got err=%b busy=%b wr_req=%b, required err=001 busy=1 wr_req=0", err, busy, wr_req);
        end
        ss_n = 1'b1;
        tick(1);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_exit: got busy=%b, required 0", busy);
        end
        send_word(32'hA5_00_01_00);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ss_high_ignored: got busy=%b, required 0", busy);
        end
        ss_n = 1'b0;
        send_word(32'hA5_00_00_00);
        tests_run++;
        if (err !== 3'b001 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_count: got err=%b busy=%b, required err=001 busy=1", err, busy);
        end
        ss_n = 1'b1;
        tick(1);
        ss_n = 1'b0;
        send_word(32'hA5_20_01_00);
        tests_run++;
        if (err !== 3'b000) begin
            tests_failed++;
            $display("FAIL err_clear: got %b, required 000", err);
        end
        expect_wr(8'h20, 32'h77); send_word(32'h77);
        wait_idle("recover");
        ss_n = 1'b1;
        tests_run++;
        if (wr_count - w0 != 1) begin
            tests_failed++;
            $display("FAIL bad_header_writes: got %0d, required 1", wr_count - w0);
        end
    endtask

    task automatic test_overflow();
        int d0, w0;
        d0 = done_count;
        w0 = wr_count;
        wr_gnt = 1'b0;
        ss_n   = 1'b0;
        send_word(32'hA5_00_06_00);
        tests_run++;
        if (wr_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL req_early: got wr_req=%b after header, required 0", wr_req);
        end
        for (int i = 0; i < 6; i++) begin
            if (i < 4) expect_wr(8'(i), 32'hC0 + 32'(i));
            send_word(32'hC0 + 32'(i));
            if (i == 0) begin
                tests_run++;
                if (wr_req !== 1'b1 || wr_addr !== 8'h00 || wr_data !== 32'hC0) begin
                    tests_failed++;
                    $display("FAIL req_latency: got wr_req=%b addr=%h data=%h, required 1 00 000000c0", wr_req, wr_addr, wr_data);
                end
            end
        end
        tests_run++;
        if (err !== 3'b010 || wr_addr !== 8'h00 || wr_data !== 32'hC0) begin
            tests_failed++;
            $display("FAIL overflow_state: got err=%b addr=%h data=%h, required err=010 addr=00 data=000000c0", err, wr_addr, wr_data);
        end
        tick(1);
        wr_gnt = 1'b1;
        wait_idle("overflow");
        ss_n = 1'b1;
        tests_run++;
        if (wr_count - w0 != 4 || done_count - d0 != 1 || err !== 3'b010) begin
            tests_failed++;
            $display("FAIL overflow_drain: got writes=%0d done=%0d err=%b, required 4 1 010", wr_count - w0, done_count - d0, err);
        end
    endtask

    task automatic test_full_push_pop();
        int w0;
        w0 = wr_count;
        wr_gnt = 1'b0;
        ss_n   = 1'b0;
        send_word(32'hA5_60_06_00);
        for (int i = 0; i < 6; i++) begin
            if (i == 4) wr_gnt = 1'b1;
            expect_wr(8'h60 + 8'(i), 32'hD0 + 32'(i));
            send_word(32'hD0 + 32'(i));
        end
        wait_idle("full_pp");
        ss_n = 1'b1;
        tests_run++;
        if (wr_count - w0 != 6 || err !== 3'b000) begin
            tests_failed++;
            $display("FAIL full_push_pop: got writes=%0d err=%b, required 6 000", wr_count - w0, err);
        end
    endtask

    task automatic test_abort();
        int d0, w0;
        d0 = done_count;
        w0 = wr_count;
        wr_gnt = 1'b0;
        ss_n   = 1'b0;
        send_word(32'hA5_40_04_00);
        send_word(32'hE0);
        send_word(32'hE1);
        ss_n = 1'b1;
        tick(1);
        tests_run++;
        if (err !== 3'b100 || busy !== 1'b0 || wr_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_state: got err=%b busy=%b wr_req=%b, required 100 0 0", err, busy, wr_req);
        end
        wr_gnt = 1'b1;
        tick(10);
        tests_run++;
        if (wr_count != w0 || done_count != d0) begin
            tests_failed++;
            $display("FAIL abort_quiet: got writes=%0d done=%0d, required 0 0", wr_count - w0, done_count - d0);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        wr_gnt = 1'b0;
        ss_n   = 1'b0;
        send_word(32'hA5_50_04_00);
        send_word(32'hF0);
        send_word(32'hF1);
        tests_run++;
        if (wr_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_queued: got wr_req=%b, required 1", wr_req);
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (wr_req !== 1'b0 || busy !== 1'b0 || err !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got wr_req=%b busy=%b err=%b, required 0 0 000", wr_req, busy, err);
        end
        tick(2);
        reset = 1'b1;
        ss_n  = 1'b1;
        w0 = wr_count;
        wr_gnt = 1'b1;
        tick(10);
        tests_run++;
        if (wr_count != w0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_discard: got writes=%0d busy=%b, required 0 0", wr_count - w0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_fixed_wrap();
        test_bad_header();
        test_overflow();
        test_full_push_pop();
        test_abort();
        test_reset_mid();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL final_pending: got %0d writes outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, received word and write-data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, register write-address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, write-buffer entries, power of two, at least 2.
REQ-004 SHALL have port SCLK  in  1  clock; all state is updated on the rising edge.
REQ-005 SHALL have port reset  in  1  reset: asynchronous, active-low.
REQ-006 SHALL have port ss_n  in  1  frame select, active low.
REQ-007 SHALL have port word_valid  in  1  one-cycle pulse per received word.
REQ-008 SHALL have port word_data  in  DATA_WIDTH  received word.
REQ-009 SHALL have port wr_req  out  1  write request; high while the FIFO is non-empty.
REQ-010 SHALL have port wr_addr  out  ADDR_WIDTH  address of the FIFO head entry.
REQ-011 SHALL have port wr_data  out  DATA_WIDTH  data of the FIFO head entry.
REQ-012 SHALL have port wr_gnt  in  1  grant; a write transfers on a cycle where wr_req and wr_gnt are both high.
REQ-013 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-014 SHALL have port done  out  1  one-cycle pulse after the last write of a command.
REQ-015 SHALL have port err  out  3  sticky status: [0] bad header, [1] overflow, [2] abort.

Function
REQ-016 Header word fields SHALL be: [31:24] opcode, [23:16] start address, [15:8] word count N, [7:0] reserved.
REQ-017 Opcode 0xA5 SHALL select incrementing-address burst; opcode 0x5A SHALL select fixed-address burst.
REQ-018 FSM states SHALL be IDLE, DATA, DRAIN, ERR.
REQ-019 IDLE, word_valid with ss_n low and a valid header SHALL clear err, load address and remaining=N, and go to DATA on the next edge.
REQ-020 IDLE, word_valid with an unknown opcode or N=0 SHALL set err[0] and go to ERR.
REQ-021 DATA, each word_valid SHALL push {address, word} into the FIFO and decrement remaining.
REQ-022 In incrementing mode, the address SHALL increment after each push and SHALL wrap from 0xFF to 0x00.
REQ-023 DATA, the push that brings remaining to 0 SHALL move the FSM to DRAIN.
REQ-024 DRAIN, when the FIFO is empty, the FSM SHALL go to IDLE and pulse done for one cycle; ss_n is ignored in DRAIN.
REQ-025 ERR SHALL ignore all words and return to IDLE on the first edge with ss_n high.
REQ-026 ss_n high while in DATA SHALL flush the FIFO, set err[2], go to IDLE, and SHALL NOT pulse done.
REQ-027 A push into a full FIFO with no pop in the same cycle SHALL drop the word, set err[1], and still decrement remaining.
REQ-028 A simultaneous push and pop on a full FIFO SHALL accept both.
REQ-029 wr_req SHALL assert on the edge after the first push (one-cycle latency); wr_addr and wr_data SHALL be stable while wr_req is high and wr_gnt is low.
REQ-030 word_valid with ss_n high SHALL be ignored in every state.

Reset
REQ-031 Asserting reset SHALL force IDLE, empty the FIFO, and drive wr_req=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0.
REQ-032 Reset asserted mid-command SHALL discard all pending writes, with no write issued after deassertion.

Configuration
REQ-033 Macro SPI_SEQ_PARITY_EN defined: header bit[0] SHALL be even parity over bits [31:1]; a mismatch sets err[0] and goes to ERR.
REQ-034 Macro SPI_SEQ_PARITY_EN undefined: header bits [7:0] SHALL be ignored.

Structure
REQ-035 Package spi_seq_pkg SHALL hold the opcode constants, the state enum, the err bit indices and the header field positions.
REQ-036 The FIFO SHALL be a sub-module spi_seq_fifo with push, pop, flush, full and empty.

Verification
REQ-037 Header 0xA5_10_03_00 then words 0x11, 0x22, 0x33, wr_gnt tied high -> writes (0x10,0x11), (0x11,0x22), (0x12,0x33); done pulses once; err=0.
REQ-038 Header 0x5A_FF_02_00, words 0xA, 0xB -> both written to 0xFF; with opcode 0xA5 -> addresses 0xFF then 0x00.
REQ-039 Header 0xA5_00_06_00, wr_gnt held low, 6 words -> 4 accepted, err[1]=1; after wr_gnt rises, exactly 4 writes occur.
REQ-040 Header 0x33_00_01_00 -> err=3'b001, no writes; ss_n high -> IDLE; next valid header clears err.
REQ-041 Header count 4, ss_n raised after 2 words -> FIFO flushed, err[2]=1, done stays low, busy falls.
REQ-042 Reset asserted with 2 entries queued -> wr_req=0 immediately, and no writes occur after release.
